// File: rtl/normal_histogram_pkg.sv
// Shared binning defaults and FSM state encoding for the normal-sample histogram.
// Top level and bench both import this so they agree on bin geometry.
package normal_stats_pkg;

  localparam int BIN_BITS_DEF  = 4;
  localparam int COUNT_W_DEF   = 16;
  localparam int TOTAL_W_DEF   = 20;
  localparam int BIN_SHIFT_DEF = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } hist_state_e;

endpackage

// File: rtl/normal_histogram_if.sv
// Control, sample and readout signals of normal_histogram.
// The master side drives the run/sample/read requests; the slave side is the histogram.
interface normal_histogram_if
  import normal_stats_pkg::*;
#(
  parameter int BIN_BITS = BIN_BITS_DEF,
  parameter int COUNT_W  = COUNT_W_DEF,
  parameter int TOTAL_W  = TOTAL_W_DEF
);
  logic                start;
  logic [TOTAL_W-1:0]  target;
  logic                in_valid;
  logic [31:0]         number;
  logic                busy;
  logic                done;
  logic                overflow;
  logic                rd_en;
  logic [BIN_BITS-1:0] rd_addr;
  logic                rd_valid;
  logic [COUNT_W-1:0]  rd_data;

  modport master (
    output start, target, in_valid, number, rd_en, rd_addr,
    input  busy, done, overflow, rd_valid, rd_data
  );

  modport slave (
    input  start, target, in_valid, number, rd_en, rd_addr,
    output busy, done, overflow, rd_valid, rd_data
  );
endinterface

// File: rtl/normal_histogram_bin_index.sv
// Maps a signed Q16.16 sample to a histogram bin: arithmetic shift, centre offset, clamp.
module hist_bin_index #(
  parameter int BIN_BITS  = 4,
  parameter int BIN_SHIFT = 14
) (
  input  logic signed [31:0] number_i,
  output logic [BIN_BITS-1:0] idx_o
);
  localparam logic signed [31:0] HALF = 32'sd1 <<< (BIN_BITS - 1);
  localparam logic signed [31:0] TOP  = (32'sd1 <<< BIN_BITS) - 32'sd1;

  logic signed [31:0] shifted;
  logic signed [31:0] offset;

  // Shifting first keeps the offset add far from 32-bit overflow for any input.
  always_comb begin
    shifted = number_i >>> BIN_SHIFT;
    offset  = shifted + HALF;
    if (offset < 32'sd0) begin
      idx_o = '0;
    end else if (offset > TOP) begin
      idx_o = '1;
    end else begin
      idx_o = offset[BIN_BITS-1:0];
    end
  end
endmodule

// File: rtl/normal_histogram.sv
// Saturating histogram of a run of normal samples, cleared at run start, read out after.
// state   | meaning
// IDLE    | after reset, bins readable, waiting for start
// CLEAR   | zeroing one bin per cycle
// COLLECT | binning accepted samples until the latched target count
// DONE    | run finished, counts held and readable
module normal_histogram
  import normal_stats_pkg::*;
#(
  parameter int BIN_BITS  = BIN_BITS_DEF,
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int TOTAL_W   = TOTAL_W_DEF,
  parameter int BIN_SHIFT = BIN_SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  normal_histogram_if.slave hist_if
);
  localparam int NBINS = 1 << BIN_BITS;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  hist_state_e         state_q, state_d;
  logic [TOTAL_W-1:0]  target_q, target_d;
  logic [TOTAL_W-1:0]  cnt_q, cnt_d;
  logic [BIN_BITS-1:0] clr_addr_q, clr_addr_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_valid_q;
  logic [COUNT_W-1:0]  rd_data_q;
  logic [COUNT_W-1:0]  bins_q [NBINS];
  logic [BIN_BITS-1:0] idx;
  logic                bin_clr;
  logic                bin_inc;
  logic                rd_ok;

  hist_bin_index #(
    .BIN_BITS (BIN_BITS),
    .BIN_SHIFT(BIN_SHIFT)
  ) u_bin_index (
    .number_i(hist_if.number),
    .idx_o   (idx)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    clr_addr_d = clr_addr_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = done_q;
    bin_clr    = 1'b0;
    bin_inc    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (hist_if.start) begin
          state_d    = CLEAR;
          target_d   = hist_if.target;
          cnt_d      = '0;
          clr_addr_d = '0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      CLEAR: begin
        bin_clr    = 1'b1;
        clr_addr_d = clr_addr_q + BIN_BITS'(1);
        if (&clr_addr_q) begin
          if (target_q == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (hist_if.in_valid) begin
          bin_inc = 1'b1;
          cnt_d   = cnt_q + TOTAL_W'(1);
          if (bins_q[idx] == CNT_MAX) overflow_d = 1'b1;
          if (cnt_d == target_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      cnt_q      <= '0;
      clr_addr_q <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      clr_addr_q <= clr_addr_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // One write port: clear and increment are mutually exclusive by state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
    end else if (bin_clr) begin
      bins_q[clr_addr_q] <= '0;
    end else if (bin_inc && (bins_q[idx] != CNT_MAX)) begin
      bins_q[idx] <= bins_q[idx] + COUNT_W'(1);
    end
  end

  assign rd_ok = hist_if.rd_en && !busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) rd_data_q <= bins_q[hist_if.rd_addr];
    end
  end

  assign hist_if.busy     = busy_q;
  assign hist_if.done     = done_q;
  assign hist_if.overflow = overflow_q;
  assign hist_if.rd_valid = rd_valid_q;
  assign hist_if.rd_data  = rd_data_q;
endmodule

// File: doc/normal_histogram.md
# normal_histogram

Downstream consumer of the `normalRandom` output word. It bins a run of accepted samples into a saturating histogram so the bench and the on-chip self-test can check the distribution shape. After a run completes, the bins are read out through a registered single-port read interface. It sits after `normalRandom` in the top level; the top level drives `in_valid` once per completed transform, on the 5-bit counter wrap.

## Interface
- `BIN_BITS`, 4: log2 of the bin count (16 bins).
- `COUNT_W`, 16: width of each bin counter.
- `TOTAL_W`, 20: width of the run-length target and the sample counter.
- `BIN_SHIFT`, 14: right-shift applied to the sample to form the bin; 0.25 per bin in Q16.16.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset is asynchronous and active-low (`rst`=0 resets); the polarity and synchronicity are fixed.
- `start` in 1: single-cycle pulse that begins a clear-and-collect run.
- `target` in TOTAL_W: number of samples per run, sampled on `start`.
- `in_valid` in 1: `number` is valid this cycle.
- `number` in 32: signed Q16.16 sample.
- `busy` out 1: high in CLEAR and COLLECT.
- `done` out 1: high in DONE.
- `overflow` out 1: sticky; some bin saturated during the run.
- `rd_en` in 1: read request.
- `rd_addr` in BIN_BITS: bin to read.
- `rd_valid` out 1: `rd_data` is valid.
- `rd_data` out COUNT_W: bin count.

## Operation
- **States:** IDLE, CLEAR, COLLECT, DONE.
- **IDLE:**
  - `start` → CLEAR; `target` is latched on this edge.
- **CLEAR:**
  - Zeroes one bin per cycle, addresses 0 to 2^BIN_BITS−1.
  - Also zeroes the sample counter and `overflow`.
  - After the last bin: → DONE if the latched target is 0, else → COLLECT.
- **COLLECT:**
  - Each `in_valid` cycle: `idx = (number >>> BIN_SHIFT) + 2^(BIN_BITS−1)`, computed as a 32-bit signed value.
  - `idx` is clamped to [0, 2^BIN_BITS−1]: negative → 0, too large → top bin.
  - `bin[idx]` increments, saturating at 2^COUNT_W−1.
  - An increment attempted on a saturated bin sets `overflow`; the count holds.
  - The sample counter increments on every accepted sample. When it reaches the latched target → DONE.
- **DONE:**
  - Holds all counts.
  - `start` → CLEAR (new run).
- **Ignored inputs:**
  - `in_valid` outside COLLECT.
  - `start` while `busy`.
  - `rd_en` while `busy`: `rd_valid` stays 0.
- **Read:** `rd_en` in IDLE or DONE returns `bin[rd_addr]` registered the next cycle.
- **Mid-run reset:** asserting `rst` during any state aborts the run. Every bin, counter and flag clears immediately.

## Timing
- **Reset values:** `busy`=0, `done`=0, `overflow`=0, `rd_valid`=0, `rd_data`=0, all bins 0, state IDLE.
- **Run start:** `start` high at edge E gives CLEAR with `busy`=1 from E+1. CLEAR lasts 2^BIN_BITS cycles (16), so COLLECT is entered at E+17.
- **Accept latency:** a sample accepted at edge A is reflected in the bin count at A+1.
- **Back-to-back samples:** samples to the same bin on consecutive cycles must both count, with no read-modify-write hazard. The bin update is a single-cycle increment on a register array.
- **End of run:** the last accepted sample at edge A puts DONE at A+1 (`busy`=0, `done`=1). Samples presented in the cycle DONE is entered are not counted.
- **Read latency:** one cycle. `rd_en` at edge R gives `rd_valid`=1 and `rd_data` at R+1, held for exactly one cycle unless `rd_en` is repeated. Continuous `rd_en` streams one bin per cycle.
- **Sample counter:** does not wrap. `target` up to 2^TOTAL_W−1 is legal.

## Structure
- **Shared package `normal_stats_pkg`:**
  - State encoding constants IDLE, CLEAR, COLLECT, DONE.
  - Default values of `BIN_BITS`, `COUNT_W` and `BIN_SHIFT`, so the top level and the bench agree on binning.
- **Sub-module `hist_bin_index`:** combinational shift, offset and clamp from `number` to `idx`. It is natural to split out so it can be unit-tested exhaustively at the boundaries.

## Test plan
- **Reset:** `rst` low mid-COLLECT with 5 samples in → all outputs 0 and state IDLE immediately. A readout after the next `start` shows all bins 0.
- **Binning boundaries:** `target`=6, samples 0x0000_0000, 0x0000_3FFF, 0xFFFF_FFFF, 0x7FFF_FFFF, 0x8000_0000, 0x0001_C000 → bins 8, 8, 7, 15, 0, 15. `done` at the cycle after the 6th sample.
- **Back-to-back same bin:** `target`=4, four consecutive cycles of 0x0000_4000 → bin 9 reads 4; all other bins read 0.
- **Saturation:** `COUNT_W`=2, `target`=5, all samples 0 → bin 8 reads 3 and `overflow`=1 at DONE.
- **Control corner cases:**
  - `target`=0 → DONE 16 cycles after CLEAR starts, all bins 0.
  - `start` and `rd_en` during COLLECT → ignored, with `rd_valid` staying 0.
  - `in_valid` in DONE → counts unchanged.
- **Streamed readout:** `rd_en` held for 16 cycles with `rd_addr` 0..15 → `rd_valid` high for 16 cycles starting one cycle later, with the data matching the bench's reference histogram of 1000 `normalRandom` samples.
